// File: rtl/cpu_nios_debug_mem_sequencer_if.sv
// Avalon-MM master bus between the debug memory sequencer and the CPU data bus.
interface cpu_nios_debug_mem_sequencer_if #(
   parameter int ADDR_W = 18
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;
   logic              waitrequest;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest
   );
endinterface

// File: rtl/cpu_nios_debug_mem_sequencer.sv
// Debug memory sequencer: turns ocimem pulses plus jdo into auto-incrementing Avalon-MM word accesses.
// Optional macro DBG_MEM_TIMEOUT_EN adds a waitrequest timeout (TIMEOUT_CYCLES).
module cpu_nios_debug_mem_sequencer #(
   parameter int ADDR_W = 18
`ifdef DBG_MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [37:0]                            jdo,
   input  logic                                   take_action_ocimem_a,
   input  logic                                   take_action_ocimem_b,
   input  logic                                   take_no_action_ocimem_a,
   output logic [31:0]                            MonDReg,
   output logic                                   monitor_ready,
   output logic                                   monitor_error,
   cpu_nios_debug_mem_sequencer_if.master         avm
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_mon_d;
   logic              r_ready;
   logic              r_error;
   logic              r_read;
   logic              r_write;
   logic [31:0]       r_wdata;
   logic              w_any_pulse;
   logic              w_unused_jdo;

`ifdef DBG_MEM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]  r_tmo;
`endif

   assign w_any_pulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign w_unused_jdo = ^{jdo[37:36], jdo[33:32]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_mon_d <= '0;
         r_ready <= 1'b1;
         r_error <= 1'b0;
         r_read  <= 1'b0;
         r_write <= 1'b0;
         r_wdata <= '0;
`ifdef DBG_MEM_TIMEOUT_EN
         r_tmo   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
`ifdef DBG_MEM_TIMEOUT_EN
               r_tmo <= '0;
`endif
               // Priority b > a > no_action; losers in the same cycle are dropped.
               if (take_action_ocimem_b) begin
                  r_wdata <= jdo[31:0];
                  r_mon_d <= jdo[31:0];
                  r_ready <= 1'b0;
                  r_write <= 1'b1;
                  r_state <= ST_WRITE;
               end else if (take_action_ocimem_a) begin
                  r_addr <= {jdo[ADDR_W-1:2], 2'b00};
                  if (jdo[34]) begin
                     r_error <= 1'b0;
                  end
                  if (jdo[35]) begin
                     r_ready <= 1'b0;
                     r_read  <= 1'b1;
                     r_state <= ST_READ;
                  end
               end else if (take_no_action_ocimem_a) begin
                  r_ready <= 1'b0;
                  r_read  <= 1'b1;
                  r_state <= ST_READ;
               end
            end

            ST_READ, ST_WRITE: begin
               // Commands during a transfer are rejected but never disturb it.
               if (w_any_pulse) begin
                  r_error <= 1'b1;
               end
               if (!avm.waitrequest) begin
                  if (r_state == ST_READ) begin
                     r_mon_d <= avm.readdata;
                  end
                  r_addr  <= r_addr + ADDR_W'(4);
                  r_read  <= 1'b0;
                  r_write <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
`ifdef DBG_MEM_TIMEOUT_EN
               else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  if (r_state == ST_READ) begin
                     r_mon_d <= 32'hDEAD_BEEF;
                  end
                  r_error <= 1'b1;
                  r_read  <= 1'b0;
                  r_write <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
`endif
            end

            default: begin
               r_read  <= 1'b0;
               r_write <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign MonDReg        = r_mon_d;
   assign monitor_ready  = r_ready;
   assign monitor_error  = r_error;
   assign avm.address    = r_addr;
   assign avm.read       = r_read;
   assign avm.write      = r_write;
   assign avm.writedata  = r_wdata;
   assign avm.byteenable = 4'b1111;
endmodule

// File: tb/tb_cpu_nios_debug_mem_sequencer.sv
// Directed bench for cpu_nios_debug_mem_sequencer; define DBG_MEM_TIMEOUT_EN to add the timeout case.
module tb_cpu_nios_debug_mem_sequencer;
   localparam int ADDR_W = 18;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        ta_a, ta_b, tna_a;
   logic [31:0] mon_d;
   logic        mon_ready, mon_error;
   int          vectors = 0;
   int          errs    = 0;

   cpu_nios_debug_mem_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DBG_MEM_TIMEOUT_EN
   cpu_nios_debug_mem_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
`else
   cpu_nios_debug_mem_sequencer #(.ADDR_W(ADDR_W)) dut (
`endif
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta_a),
      .take_action_ocimem_b    (ta_b),
      .take_no_action_ocimem_a (tna_a),
      .MonDReg                 (mon_d),
      .monitor_ready           (mon_ready),
      .monitor_error           (mon_error),
      .avm                     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; jdo = '0; ta_a = 0; ta_b = 0; tna_a = 0;
      bus.readdata = '0; bus.waitrequest = 1'b0;
      tick(); tick();
      check("rst_ready", 64'(mon_ready), 64'd1);
      check("rst_error", 64'(mon_error), 64'd0);
      check("rst_mon",   64'(mon_d), 64'd0);
      check("rst_rw",    64'({bus.read, bus.write}), 64'd0);
      check("rst_addr",  64'(bus.address), 64'd0);
      check("rst_be",    64'(bus.byteenable), 64'hF);
      reset = 1'b0;
      tick();

      // 1: ocimem_a with read, zero wait
      jdo = (38'd1 << 35) | 38'h100; ta_a = 1; bus.readdata = 32'h1234_5678;
      tick(); ta_a = 0;
      check("t1_read_on",  64'(bus.read), 64'd1);
      check("t1_ready_lo", 64'(mon_ready), 64'd0);
      check("t1_addr",     64'(bus.address), 64'h100);
      tick();
      check("t1_read_off", 64'(bus.read), 64'd0);
      check("t1_ready",    64'(mon_ready), 64'd1);
      check("t1_mon",      64'(mon_d), 64'h1234_5678);
      check("t1_addr_inc", 64'(bus.address), 64'h104);

      // 2: write held through three wait cycles
      jdo = 38'hCAFE_F00D; ta_b = 1; bus.waitrequest = 1;
      tick(); ta_b = 0;
      check("t2_write_on", 64'(bus.write), 64'd1);
      check("t2_wdata",    64'(bus.writedata), 64'hCAFE_F00D);
      check("t2_mon_echo", 64'(mon_d), 64'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold", 64'({bus.write, bus.read, bus.address, bus.writedata}),
               {1'b1, 1'b0, 18'h104, 32'hCAFE_F00D});
      end
      bus.waitrequest = 0;
      tick();
      check("t2_write_off", 64'(bus.write), 64'd0);
      check("t2_ready",     64'(mon_ready), 64'd1);
      check("t2_addr_inc",  64'(bus.address), 64'h108);

      // 3: read at max word wraps address to zero
      jdo = 38'h3FFFC; ta_a = 1;
      tick(); ta_a = 0;
      check("t3_noread",  64'({bus.read, mon_ready}), 64'b01);
      check("t3_addr",    64'(bus.address), 64'h3FFFC);
      tna_a = 1; bus.readdata = 32'hA5A5_5A5A;
      tick(); tna_a = 0;
      check("t3_read_on", 64'(bus.read), 64'd1);
      tick();
      check("t3_wrap",    64'(bus.address), 64'h0);
      check("t3_mon",     64'(mon_d), 64'hA5A5_5A5A);
      check("t3_err",     64'(mon_error), 64'd0);

      // 4: write beats coincident read; busy pulse sets error; ocimem_a jdo[34] clears
      jdo = 38'h1111_2222; ta_b = 1; tna_a = 1; bus.waitrequest = 1;
      tick(); ta_b = 0; tna_a = 0;
      check("t4_only_wr", 64'({bus.write, bus.read}), 64'b10);
      tna_a = 1;
      tick(); tna_a = 0;
      check("t4_err_set", 64'(mon_error), 64'd1);
      check("t4_unaff",   64'({bus.write, bus.read, bus.address}), {1'b1, 1'b0, 18'h0});
      bus.waitrequest = 0;
      tick();
      check("t4_done",    64'({bus.write, mon_ready, bus.address}), {1'b0, 1'b1, 18'h4});
      tick();
      check("t4_no_rd",   64'(bus.read), 64'd0);
      jdo = (38'd1 << 34) | 38'h200; ta_a = 1;
      tick(); ta_a = 0;
      check("t4_err_clr", 64'(mon_error), 64'd0);
      check("t4_addr",    64'(bus.address), 64'h200);

      // 5: reset mid-read
      tna_a = 1; bus.waitrequest = 1;
      tick(); tna_a = 0;
      check("t5_read_on", 64'(bus.read), 64'd1);
      tick();
      reset = 1;
      tick(); reset = 0;
      check("t5_rst", 64'({bus.read, mon_ready, bus.address, mon_d}),
            {1'b0, 1'b1, 18'h0, 32'h0});

`ifdef DBG_MEM_TIMEOUT_EN
      // 6: stuck waitrequest times out after 8 strobe cycles
      tick();
      tna_a = 1; bus.waitrequest = 1;
      tick(); tna_a = 0;
      for (int i = 0; i < 8; i++) begin
         check("t6_strobe", 64'(bus.read), 64'd1);
         tick();
      end
      check("t6_drop",  64'({bus.read, mon_ready, mon_error}), 64'b011);
      check("t6_mon",   64'(mon_d), 64'hDEAD_BEEF);
      check("t6_addr",  64'(bus.address), 64'h0);
      bus.waitrequest = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
